// File: rtl/alu_instruction_decoder.sv
// Combinational decoder for 32-bit ALU instructions: splits the word into op/control
// fields, register selects and write-back controls, plus a sticky malformed-instruction flag.
module alu_instruction_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_vec_perci,
    output logic        alu_form,
    output logic        const_c,
    output logic [15:0] constant,
    output logic [1:0]  alu_write,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic [3:0]  alu_c_select,
    output logic [3:0]  alu_d_select,
    output logic [3:0]  alu_Y1_select,
    output logic [3:0]  alu_Y2_select,
    output logic        illegal,
    output logic        illegal_seen
);

    localparam logic       FORM_FOUR_REG = 1'b0;
    localparam logic [1:0] WRITE_BOTH    = 2'b11;
    localparam logic [1:0] WRITE_Y1_ONLY = 2'b01;

    logic [3:0] field_a;
    logic [3:0] field_b;
    logic [3:0] field_c;
    logic [3:0] field_d;

    logic illegal_seen_d;
    logic illegal_seen_q;

    assign field_a = instruction[15:12];
    assign field_b = instruction[11:8];
    assign field_c = instruction[7:4];
    assign field_d = instruction[3:0];

    assign alu_op        = instruction[26:24];
    assign alu_vec_perci = instruction[23:22];
    assign alu_form      = instruction[28];
    assign const_c       = instruction[29];
    assign alu_a_select  = field_a;
    assign alu_b_select  = field_b;

    // Reserved fields: [31:30], [27] and [21:16] must all be zero.
    assign illegal = (|instruction[31:30]) | instruction[27] | (|instruction[21:16]);

    // The low byte doubles as the immediate, so it steals the c/d register fields.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        constant     = 16'h0000;
        alu_c_select = field_c;
        alu_d_select = field_d;
        if (const_c) begin
            constant     = {8'h00, instruction[7:0]};
            alu_c_select = 4'h0;
            alu_d_select = 4'h0;
        end
    end

    // Y2 uses the raw c field even when c is a constant; the write target is still encoded there.
    always_comb begin
        alu_write     = WRITE_Y1_ONLY;
        alu_Y1_select = field_a;
        alu_Y2_select = 4'h0;
        if (alu_form == FORM_FOUR_REG) begin
            alu_write     = WRITE_BOTH;
            alu_Y2_select = field_c;
        end
    end

    assign illegal_seen_d = illegal_seen_q | illegal;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples
        // pre-edge values; reset is synchronous and wins over a simultaneous illegal.
        if (rst) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_alu_instruction_decoder.sv
// Self-checking bench for alu_instruction_decoder: directed cases plus randomized
// instructions compared against a field-extraction reference model.
module tb_alu_instruction_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [2:0]  alu_op;
    logic [1:0]  alu_vec_perci;
    logic        alu_form;
    logic        const_c;
    logic [15:0] constant;
    logic [1:0]  alu_write;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic [3:0]  alu_c_select;
    logic [3:0]  alu_d_select;
    logic [3:0]  alu_Y1_select;
    logic [3:0]  alu_Y2_select;
    logic        illegal;
    logic        illegal_seen;

    int n_checks = 0;
    int n_pass   = 0;
    bit seen_model = 1'b0;

    alu_instruction_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .alu_op       (alu_op),
        .alu_vec_perci(alu_vec_perci),
        .alu_form     (alu_form),
        .const_c      (const_c),
        .constant     (constant),
        .alu_write    (alu_write),
        .alu_a_select (alu_a_select),
        .alu_b_select (alu_b_select),
        .alu_c_select (alu_c_select),
        .alu_d_select (alu_d_select),
        .alu_Y1_select(alu_Y1_select),
        .alu_Y2_select(alu_Y2_select),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %h expected %h (instr %h)", tag, obs, exp, instruction);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int unsigned fld(input logic [31:0] w, input int lo, input int width);
        return (int'(w) >>> 0 == 0 ? 0 : 0) + ((w >> lo) % (32'd1 << width));
    endfunction

    // Reference: every expected output is derived from the encoding rules directly.
    task automatic check_decode(input string tag);
        int unsigned cc, form, bad;
        cc   = fld(instruction, 29, 1);
        form = fld(instruction, 28, 1);
        bad  = (fld(instruction, 30, 2) != 0 || fld(instruction, 27, 1) != 0 ||
                fld(instruction, 16, 6) != 0) ? 1 : 0;
        check({tag, ".op"},    32'(alu_op),        fld(instruction, 24, 3));
        check({tag, ".vec"},   32'(alu_vec_perci), fld(instruction, 22, 2));
        check({tag, ".form"},  32'(alu_form),      form);
        check({tag, ".cc"},    32'(const_c),       cc);
        check({tag, ".const"}, 32'(constant),      cc == 1 ? fld(instruction, 0, 8) : 0);
        check({tag, ".write"}, 32'(alu_write),     form == 1 ? 1 : 3);
        check({tag, ".a"},     32'(alu_a_select),  fld(instruction, 12, 4));
        check({tag, ".b"},     32'(alu_b_select),  fld(instruction, 8, 4));
        check({tag, ".c"},     32'(alu_c_select),  cc == 1 ? 0 : fld(instruction, 4, 4));
        check({tag, ".d"},     32'(alu_d_select),  cc == 1 ? 0 : fld(instruction, 0, 4));
        check({tag, ".y1"},    32'(alu_Y1_select), fld(instruction, 12, 4));
        check({tag, ".y2"},    32'(alu_Y2_select), form == 1 ? 0 : fld(instruction, 4, 4));
        check({tag, ".ill"},   32'(illegal),       bad);
    endtask

    // Apply one instruction/reset pair for one clock, checking decode before the edge
    // and the sticky flag after it.
    task automatic step(input string tag, input logic [31:0] ins, input logic r);
        bit bad;
        @(negedge clk);
        instruction = ins;
        rst         = r;
        #1;
        check_decode(tag);
        bad = (ins[31:30] != 2'b00) || ins[27] || (ins[21:16] != 6'd0);
        @(posedge clk);
        seen_model = r ? 1'b0 : (seen_model | bad);
        #1;
        check({tag, ".seen"}, 32'(illegal_seen), 32'(seen_model));
    endtask

    initial begin
        logic [31:0] ins;
        rst         = 1'b1;
        instruction = 32'h0;

        step("reset", 32'h0000_0000, 1'b1);
        check("reset.seen0", 32'(illegal_seen), 32'd0);

        step("t1", 32'h0080_1234, 1'b0);
        check("t1.fixed_y2", 32'(alu_Y2_select), 32'h3);
        check("t1.fixed_vec", 32'(alu_vec_perci), 32'h2);

        step("t2", 32'h25C0_ABCD, 1'b0);
        check("t2.fixed_const", 32'(constant), 32'h00CD);
        check("t2.fixed_y2", 32'(alu_Y2_select), 32'hC);
        check("t2.fixed_c", 32'(alu_c_select), 32'h0);

        step("t3", 32'h1340_5678, 1'b0);
        check("t3.fixed_write", 32'(alu_write), 32'h1);
        check("t3.fixed_d", 32'(alu_d_select), 32'h8);

        step("t4.rst", 32'h0000_0000, 1'b1);
        step("t4.ill", 32'h8000_1234, 1'b0);
        check("t4.fixed_seen", 32'(illegal_seen), 32'd1);
        step("t4.legal", 32'h0080_1234, 1'b0);
        check("t4.fixed_hold", 32'(illegal_seen), 32'd1);
        step("t4.clr", 32'h0080_1234, 1'b1);
        check("t4.fixed_clr", 32'(illegal_seen), 32'd0);

        step("t5.prio", 32'h0001_0000, 1'b1);
        check("t5.fixed_prio", 32'(illegal_seen), 32'd0);
        step("t5.rel", 32'h0001_0000, 1'b0);
        check("t5.fixed_rel", 32'(illegal_seen), 32'd1);
        step("t5.clr", 32'h0000_0000, 1'b1);

        for (int op = 0; op < 8; op++) begin
            for (int v = 0; v < 4; v++) begin
                ins = 32'h0000_1234 | (32'(op) << 24) | (32'(v) << 22);
                step("t6", ins, 1'b0);
            end
        end

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins = ins & 32'h37C0_FFFF;
            step("rnd", ins, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
